banner_scroll_ctrl: RTL and testbench

//   Sequences one banner ROM (ROWS x ROW_W bitmap, 1-cycle registered-address read) and streams a
//   WIN_W-column window of it, row by row, to the LED-matrix row driver. One full frame per

---
 rtl/banner_pkg.sv | 19 +
 rtl/banner_window_rot.sv | 29 ++
 rtl/banner_scroll_ctrl.sv | 119 +++++++++++
 tb/tb_banner_scroll_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/banner_pkg.sv
// Shared sizes and FSM state type for the banner scroller.
package banner_pkg;

    localparam int DEF_ROWS        = 15;
    localparam int DEF_ROW_W       = 70;
    localparam int DEF_WIN_W       = 32;
    localparam int DEF_SCROLL_STEP = 1;
    localparam int DEF_AW          = 5;
    localparam int OFF_W           = 7;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        FETCH,
        SEND,
        DONE
    } scroll_state_t;

endpackage

// File: rtl/banner_window_rot.sv
// Combinational circular window select: picks WIN_W columns of a ROM row starting at offset.
module banner_window_rot
    import banner_pkg::*;
#(
    parameter int ROW_W = DEF_ROW_W,
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic [ROW_W-1:0] rom_data,
    input  logic [OFF_W-1:0] offset,
    output logic [WIN_W-1:0] row_data
);

    int unsigned col;

    // Column c of the window is banner column (offset + c) wrapped once; offset < ROW_W
    // and WIN_W <= ROW_W, so one subtraction is enough.
    always_comb begin
        row_data = '0;
        col      = 0;
        for (int c = 0; c < WIN_W; c++) begin
            col = int'(offset) + c;
            if (col >= ROW_W) begin
                col = col - ROW_W;
            end
            row_data[WIN_W-1-c] = rom_data[ROW_W-1-col];
        end
    end

endmodule

// File: rtl/banner_scroll_ctrl.sv
// Banner ROM sequencer streaming a scrolling window row by row to the LED row driver.
// Optional BANNER_SCROLL_PAUSE_EN adds a `pause` input that freezes the scroll offset.
module banner_scroll_ctrl
    import banner_pkg::*;
#(
    parameter int ROWS        = DEF_ROWS,
    parameter int ROW_W       = DEF_ROW_W,
    parameter int WIN_W       = DEF_WIN_W,
    parameter int SCROLL_STEP = DEF_SCROLL_STEP,
    parameter int AW          = DEF_AW
) (
    input  logic             clk,
    input  logic             rst,
`ifdef BANNER_SCROLL_PAUSE_EN
    input  logic             pause,
`endif
    input  logic             enable,
    input  logic             frame_tick,
    output logic [AW-1:0]    rom_addr,
    input  logic [ROW_W-1:0] rom_data,
    output logic [WIN_W-1:0] row_data,
    output logic [AW-1:0]    row_idx,
    output logic             row_valid,
    input  logic             row_ready,
    output logic             frame_done,
    output logic             busy,
    output logic             overrun,
    output logic [OFF_W-1:0] offset
);

    scroll_state_t    state;
    logic [AW-1:0]    row;
    logic [WIN_W-1:0] win_data;
    logic [OFF_W:0]   off_sum;
    logic [OFF_W-1:0] next_offset;
    logic             advance;

    assign rom_addr = row;

`ifdef BANNER_SCROLL_PAUSE_EN
    assign advance = ~pause;
`else
    assign advance = 1'b1;
`endif

    banner_window_rot #(
        .ROW_W (ROW_W),
        .WIN_W (WIN_W)
    ) u_window_rot (
        .rom_data (rom_data),
        .offset   (offset),
        .row_data (win_data)
    );

    always_comb begin
        off_sum     = {1'b0, offset} + (OFF_W+1)'(SCROLL_STEP);
        next_offset = off_sum[OFF_W-1:0];
        if (off_sum >= (OFF_W+1)'(ROW_W)) begin
            next_offset = OFF_W'(off_sum - (OFF_W+1)'(ROW_W));
        end
    end

    // Offset only moves in DONE, so the window is stable for every row of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            row_idx    <= '0;
            row_data   <= '0;
            row_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            offset     <= '0;
        end else begin
            frame_done <= 1'b0;
            overrun    <= frame_tick && (state != IDLE);
            case (state)
                IDLE: begin
                    if (frame_tick && enable) begin
                        row   <= '0;
                        busy  <= 1'b1;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    state <= FETCH;
                end
                FETCH: begin
                    row_data  <= win_data;
                    row_idx   <= row;
                    row_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (row_ready) begin
                        row_valid <= 1'b0;
                        if (row == AW'(ROWS-1)) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            row   <= row + 1'b1;
                            state <= ADDR;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (advance) begin
                        offset <= next_offset;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// Directed bench for banner_scroll_ctrl with a 70x15 registered-address ROM model.
module tb_banner_scroll_ctrl;

    localparam int ROWS  = 15;
    localparam int ROW_W = 70;
    localparam int WIN_W = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             frame_tick;
    logic             row_ready;
    logic [AW-1:0]    rom_addr;
    logic [ROW_W-1:0] rom_data;
    logic [WIN_W-1:0] row_data;
    logic [AW-1:0]    row_idx;
    logic             row_valid;
    logic             frame_done;
    logic             busy;
    logic             overrun;
    logic [6:0]       offset;
`ifdef BANNER_SCROLL_PAUSE_EN
    logic             pause;
`endif

    logic [ROW_W-1:0] rom_mem [0:31];
    int total = 0;
    int bad   = 0;

    banner_scroll_ctrl dut (
        .clk        (clk),
        .rst        (rst),
`ifdef BANNER_SCROLL_PAUSE_EN
        .pause      (pause),
`endif
        .enable     (enable),
        .frame_tick (frame_tick),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .row_data   (row_data),
        .row_idx    (row_idx),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .frame_done (frame_done),
        .busy       (busy),
        .overrun    (overrun),
        .offset     (offset)
    );

    always #5 clk = ~clk;

    // ROM with a registered address: data follows the address one clock later.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIN_W-1:0] expWin(input int r, input int off);
        logic [ROW_W-1:0] line;
        logic [WIN_W-1:0] w;
        int idx;
        line = rom_mem[r];
        w = '0;
        for (int c = 0; c < WIN_W; c++) begin
            idx = (off + c) % ROW_W;
            w[WIN_W-1-c] = line[ROW_W-1-idx];
        end
        return w;
    endfunction

    task automatic applyStimulus(input logic tick, input logic en);
        frame_tick = tick;
        enable     = en;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic runFrame(input int off, input int exp_next, input int stall_row,
                            input int tick_row, input bit chk_lat);
        int cyc, exp_row, stall_cnt, ovr_cnt, first_valid;
        bit done_seen, ticked;
        cyc = 1; exp_row = 0; stall_cnt = 0; ovr_cnt = 0; first_valid = -1;
        done_seen = 1'b0; ticked = 1'b0;
        row_ready = 1'b1;
        applyStimulus(1'b1, 1'b1);
        checkOutput("busy_start", 64'(busy), 64'd1);
        while (!done_seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            frame_tick = 1'b0;
            if (overrun) ovr_cnt++;
            if (frame_done) begin
                done_seen = 1'b1;
                checkOutput("rows_seen", 64'(exp_row), 64'(ROWS));
                checkOutput("valid_at_done", 64'(row_valid), 64'd0);
            end else if (row_valid) begin
                if (first_valid < 0) first_valid = cyc;
                checkOutput("row_idx", 64'(row_idx), 64'(exp_row));
                checkOutput("row_data", 64'(row_data), 64'(expWin(exp_row, off)));
                checkOutput("offset_mid", 64'(offset), 64'(off));
                if (tick_row == exp_row && !ticked) begin
                    frame_tick = 1'b1;
                    ticked = 1'b1;
                end
                if (exp_row == stall_row && stall_cnt < 5) begin
                    row_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    row_ready = 1'b1;
                    exp_row++;
                end
            end
        end
        checkOutput("frame_done_seen", 64'(done_seen), 64'd1);
        if (chk_lat) checkOutput("latency", 64'(first_valid), 64'd3);
        @(negedge clk);
        if (overrun) ovr_cnt++;
        checkOutput("done_pulse", 64'(frame_done), 64'd0);
        checkOutput("busy_end", 64'(busy), 64'd0);
        checkOutput("offset_next", 64'(offset), 64'(exp_next));
        checkOutput("overrun_cnt", 64'(ovr_cnt), (tick_row >= 0) ? 64'd1 : 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("no_second_frame", 64'({busy, row_valid}), 64'd0);
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_row_valid"}, 64'(row_valid), 64'd0);
        checkOutput({tag, "_row_data"}, 64'(row_data), 64'd0);
        checkOutput({tag, "_row_idx"}, 64'(row_idx), 64'd0);
        checkOutput({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        checkOutput({tag, "_overrun"}, 64'(overrun), 64'd0);
        checkOutput({tag, "_offset"}, 64'(offset), 64'd0);
    endtask

    initial begin
        logic [63:0] m;
        bit hit;
        rst = 1'b1; enable = 1'b0; frame_tick = 1'b0; row_ready = 1'b0;
`ifdef BANNER_SCROLL_PAUSE_EN
        pause = 1'b0;
`endif
        for (int r = 0; r < 32; r++) rom_mem[r] = '0;
        for (int r = 0; r < ROWS; r++) begin
            m = 64'h9E37_79B9_7F4A_7C15 * 64'(r + 1);
            rom_mem[r] = {6'(r * 5 + 3) ^ 6'h2A, m};
        end
        #1;
        checkZero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Tick with enable low in IDLE: nothing starts, no overrun.
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("disabled_busy", 64'(busy), 64'd0);
            checkOutput("disabled_overrun", 64'(overrun), 64'd0);
            @(negedge clk);
        end

        runFrame(0, 1, -1, -1, 1'b1);
        runFrame(1, 2, 7, -1, 1'b0);
        runFrame(2, 3, -1, 3, 1'b0);
        for (int f = 3; f < 68; f++) runFrame(f, f + 1, -1, -1, 1'b0);
        runFrame(68, 69, -1, -1, 1'b0);
        runFrame(69, 0, -1, -1, 1'b0);
        runFrame(0, 1, -1, -1, 1'b0);

        // Abandon a frame with reset while row 9 is waiting in SEND.
        row_ready = 1'b1;
        applyStimulus(1'b1, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (row_valid && row_idx == 5'd9) begin
                hit = 1'b1;
                row_ready = 1'b0;
            end
        end
        checkOutput("reached_row9", 64'(hit), 64'd1);
        #2 rst = 1'b1;
        #1;
        checkZero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        runFrame(0, 1, -1, -1, 1'b1);

`ifdef BANNER_SCROLL_PAUSE_EN
        pause = 1'b1;
        repeat (3) runFrame(1, 1, -1, -1, 1'b0);
        pause = 1'b0;
        runFrame(1, 2, -1, -1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
